joystick_reader: RTL and testbench

SPI master that polls the joystick module and produces the quantized `Joystick_data` word consumed by the player-position logic, plus Y axis and button state. It runs the 5-byte joystick transaction periodically and drives the LED command byte. All outputs hold their last sampled values between polls.

---
 rtl/joystick_reader.sv | 111 +++++++++++
 tb/tb_joystick_reader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/joystick_reader.sv
// joystick_reader: SPI master polling a joystick, quantizing X/Y and capturing buttons
module joystick_reader #(
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Led,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  output logic [3:0] Joystick_data,
  output logic [3:0] Joystick_Y,
  output logic [2:0] Buttons,
  output logic       Data_Valid
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int CW = $clog2(SS_SETUP + BYTE_GAP + CLK_DIV + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;
  state_t state;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, byte_idx, btn_sh;
  logic [7:0] tx, rx;
  logic [9:0] x_sh, y_sh;
  logic [1:0] led_q;
  logic wrap;
  assign wrap = poll_cnt == PW'(POLL_PERIOD - 1);
  // free-running poll timer, wraps every POLL_PERIOD cycles
  always_ff @(posedge Clk)
    if (!Reset) poll_cnt <= '0;
    else poll_cnt <= wrap ? '0 : poll_cnt + 1'b1;
  // transaction sequencer; the wrap cycle counts as the first setup cycle and DONE as the last SS-low slot
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      SS <= 1'b1;
      SCLK <= 1'b0;
      MOSI <= 1'b0;
      Data_Valid <= 1'b0;
      Joystick_data <= 4'd5;
      Joystick_Y <= 4'd5;
      Buttons <= '0;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      tx <= '0;
      rx <= '0;
      x_sh <= '0;
      y_sh <= '0;
      btn_sh <= '0;
      led_q <= '0;
    end else begin
      Data_Valid <= 1'b0;
      case (state)
        IDLE: if (wrap) begin
          state <= SETUP;
          SS <= 1'b0;
          led_q <= Led;
          cnt <= CW'(1);
        end
        SETUP: if (cnt == CW'(SS_SETUP - 1)) begin
          state <= SHIFT;
          cnt <= '0;
          bit_idx <= '0;
          byte_idx <= '0;
          tx <= {6'b100000, led_q};
          MOSI <= 1'b1;
        end else cnt <= cnt + 1'b1;
        SHIFT: if (cnt != CW'(CLK_DIV - 1)) cnt <= cnt + 1'b1;
        else begin
          cnt <= '0;
          SCLK <= ~SCLK;
          if (!SCLK) rx <= {rx[6:0], MISO};
          else if (bit_idx != 3'd7) begin
            bit_idx <= bit_idx + 1'b1;
            MOSI <= tx[6];
            tx <= {tx[6:0], 1'b0};
          end else begin
            MOSI <= 1'b0;
            state <= byte_idx == 3'd4 ? DONE : GAP;
            if (byte_idx == 3'd0) x_sh[7:0] <= rx;
            if (byte_idx == 3'd1) x_sh[9:8] <= rx[1:0];
            if (byte_idx == 3'd2) y_sh[7:0] <= rx;
            if (byte_idx == 3'd3) y_sh[9:8] <= rx[1:0];
            if (byte_idx == 3'd4) btn_sh <= rx[2:0];
          end
        end
        GAP: if (cnt == CW'(BYTE_GAP - 1)) begin
          state <= SHIFT;
          cnt <= '0;
          bit_idx <= '0;
          byte_idx <= byte_idx + 1'b1;
          tx <= '0;
        end else cnt <= cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          SS <= 1'b1;
          Data_Valid <= 1'b1;
          Joystick_data <= {1'b0, x_sh[9:7]} + 4'd1;
          Joystick_Y <= {1'b0, y_sh[9:7]} + 4'd1;
          Buttons <= btn_sh;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_joystick_reader.sv
// tb_joystick_reader: directed vectors against a mode-0 joystick slave model
module tb_joystick_reader;
  localparam int CD = 2, SU = 4, BG = 3, PP = 200, TL = 176;
  logic Clk = 0, Reset = 0, MISO = 0;
  logic [1:0] Led = 0;
  logic SS, SCLK, MOSI, Data_Valid;
  logic [3:0] Joystick_data, Joystick_Y;
  logic [2:0] Buttons;
  joystick_reader #(.CLK_DIV(CD), .SS_SETUP(SU), .BYTE_GAP(BG), .POLL_PERIOD(PP)) dut (
    .Clk(Clk), .Reset(Reset), .Led(Led), .MISO(MISO), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .Joystick_data(Joystick_data), .Joystick_Y(Joystick_Y), .Buttons(Buttons), .Data_Valid(Data_Valid));
  always #5 Clk = ~Clk;
  typedef struct {
    logic [9:0] x, y;
    logic [2:0] b;
    logic [1:0] led;
    bit gl;
    logic [3:0] ex, ey;
    logic [7:0] em;
  } vec_t;
  vec_t v[5];
  int pass_n = 0, tot = 0;
  logic [39:0] frame = '0, mosi_cap = '0;
  bit glitch = 0, ss_q = 1;
  int k = 0;
  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    tot++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask
  function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    return {x[7:0], 6'h3F, x[9:8], y[7:0], 6'h3F, y[9:8], 5'h1F, b};
  endfunction
  // slave: first bit valid at SS fall, then shifts on each SCLK fall; optional low-phase glitch
  always @(negedge SS or posedge SS or negedge SCLK) begin
    if (SS === 1'b1) ss_q = 1;
    else if (ss_q) begin
      ss_q = 0;
      k = 0;
      MISO = frame[39];
    end else begin
      k++;
      if (k < 40) begin
        MISO = glitch ? ~frame[39-k] : frame[39-k];
        if (glitch) begin
          @(posedge Clk);
          #1 MISO = frame[39-k];
        end
      end
    end
  end
  always @(posedge SCLK) mosi_cap = {mosi_cap[38:0], MOSI};
  task automatic txn(input string tag, input logic [39:0] fr, input bit gl,
                     input logic [3:0] hx, input logic [3:0] hy, input logic [2:0] hb,
                     input logic [3:0] ex, input logic [3:0] ey, input logic [2:0] eb,
                     input int led_mid, output int lat, output logic [39:0] mo);
    bit hold = 1;
    int low = 0, rises = 0;
    logic s1 = 0, s2 = 0;
    frame = fr;
    glitch = gl;
    lat = 0;
    while (SS !== 1'b0 && lat < PP + 10) begin
      @(negedge Clk);
      lat++;
      if ({Joystick_data, Joystick_Y, Buttons, Data_Valid} !== {hx, hy, hb, 1'b0}) hold = 0;
    end
    while (SS === 1'b0 && low < TL + 10) begin
      low++;
      if (SCLK === 1'b1 && s1 === 1'b0) rises++;
      if (Data_Valid !== 1'b0 || {Joystick_data, Joystick_Y, Buttons} !== {hx, hy, hb}) hold = 0;
      if (low == 10 && led_mid >= 0) Led = 2'(led_mid);
      s2 = s1;
      s1 = SCLK;
      @(negedge Clk);
    end
    chk({tag, " ss_low"}, 40'(low), 40'(TL));
    chk({tag, " sclk_rises"}, 40'(rises), 40'd40);
    chk({tag, " done_align"}, {37'd0, Data_Valid, s1, s2}, 40'b101);
    chk({tag, " outputs"}, {29'd0, Joystick_data, Joystick_Y, Buttons}, {29'd0, ex, ey, eb});
    chk({tag, " hold"}, 40'(hold), 40'd1);
    @(negedge Clk);
    chk({tag, " dv_single"}, 40'(Data_Valid), 40'd0);
    mo = mosi_cap;
  endtask
  initial begin
    int lat, n;
    bit ok;
    logic [39:0] mo;
    logic [3:0] px, py;
    logic [2:0] pb;
    v[0] = '{x: 10'd1023, y: 10'd0,   b: 3'b101, led: 2'b10, gl: 0, ex: 4'd8, ey: 4'd1, em: 8'h82};
    v[1] = '{x: 10'd512,  y: 10'd512, b: 3'b000, led: 2'b00, gl: 0, ex: 4'd5, ey: 4'd5, em: 8'h80};
    v[2] = '{x: 10'd383,  y: 10'd767, b: 3'b111, led: 2'b01, gl: 1, ex: 4'd3, ey: 4'd6, em: 8'h81};
    v[3] = '{x: 10'd768,  y: 10'd384, b: 3'b010, led: 2'b11, gl: 1, ex: 4'd7, ey: 4'd4, em: 8'h83};
    v[4] = '{x: 10'd127,  y: 10'd896, b: 3'b001, led: 2'b00, gl: 0, ex: 4'd1, ey: 4'd8, em: 8'h80};
    repeat (3) @(negedge Clk);
    chk("reset_state", {27'd0, SS, SCLK, MOSI, Data_Valid, Joystick_data, Joystick_Y, Buttons},
        {27'd0, 4'b1000, 4'd5, 4'd5, 3'd0});
    Reset = 1;
    {px, py, pb} = {4'd5, 4'd5, 3'd0};
    for (int i = 0; i < 5; i++) begin
      Led = v[i].led;
      txn($sformatf("vec%0d", i), mk(v[i].x, v[i].y, v[i].b), v[i].gl, px, py, pb,
          v[i].ex, v[i].ey, v[i].b, -1, lat, mo);
      if (i == 0) chk("first_poll_latency", 40'(lat), 40'(PP));
      chk($sformatf("vec%0d mosi0", i), {32'd0, mo[39:32]}, {32'd0, v[i].em});
      chk($sformatf("vec%0d mosi_rest", i), {8'd0, mo[31:0]}, 40'd0);
      {px, py, pb} = {v[i].ex, v[i].ey, v[i].b};
    end
    Led = 2'b01;
    txn("led_mid", mk(10'd640, 10'd256, 3'b011), 0, px, py, pb, 4'd6, 4'd3, 3'b011, 2, lat, mo);
    chk("led_mid cur_byte0", {32'd0, mo[39:32]}, {32'd0, 8'h81});
    txn("led_next", mk(10'd640, 10'd256, 3'b011), 0, 4'd6, 4'd3, 3'b011, 4'd6, 4'd3, 3'b011, -1, lat, mo);
    chk("led_next byte0", {32'd0, mo[39:32]}, {32'd0, 8'h82});
    frame = mk(10'd0, 10'd1023, 3'b110);
    glitch = 0;
    n = 0;
    while (SS !== 1'b0 && n < PP + 10) begin
      @(negedge Clk);
      n++;
    end
    repeat (85) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("midreset state", {27'd0, SS, SCLK, Data_Valid, Joystick_data, Joystick_Y, Buttons},
        {27'd0, 3'b100, 4'd5, 4'd5, 3'd0});
    Reset = 1;
    txn("post_reset", mk(10'd900, 10'd100, 3'b100), 0, 4'd5, 4'd5, 3'd0, 4'd8, 4'd1, 3'b100, -1, lat, mo);
    chk("post_reset latency", 40'(lat), 40'(PP));
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
